// File: rtl/farrow_ctrl.sv
// farrow_ctrl: Horner-scheme sequencer for the Farrow fractional-delay filter.
// Evaluates y = (...(c[ORDER]*mu + c[ORDER-1])*mu + ...)*mu + c[0] by issuing
// ORDER passes into one shared mult_sum stage, capturing each result as the
// new accumulator. Only one pass is ever in flight in mult_sum.
// Optional feature macro: FARROW_CTRL_ZERO_MU_SKIP_EN (mu==0 bypasses mult_sum).
module farrow_ctrl #(
  parameter int wight_data  = 20,
  parameter int wight_delay = 18,
  parameter int ORDER       = 3,
  parameter int LAT         = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_vld,
  output logic                              s_rdy,
  input  logic [(ORDER+1)*wight_data-1:0]   s_coef,
  input  logic [wight_delay-1:0]            s_delay,
  output logic [wight_data-1:0]             ms_data_in,
  output logic [wight_delay-1:0]            ms_delay,
  output logic [wight_data-1:0]             ms_data_fir,
  output logic                              ms_vld,
  input  logic [wight_data-1:0]             ms_data_out,
  output logic                              m_vld,
  output logic [wight_data-1:0]             m_data,
  output logic                              busy
);

  localparam int KW = $clog2(ORDER + 1);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [KW-1:0] K_TOP  = KW'(ORDER - 1);
  localparam logic [CW-1:0] C_LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [wight_data-1:0]   r_c [0:ORDER];
  logic [wight_delay-1:0]  r_mu;
  logic [wight_data-1:0]   r_acc;
  logic [KW-1:0]           r_k;
  logic [CW-1:0]           r_cnt;
  logic [wight_data-1:0]   r_m_data;

  logic w_rdy;
  logic w_hs;
  logic w_last;
  logic w_skip;

  assign w_rdy  = (r_state == IDLE) || (r_state == OUT);
  assign w_hs   = s_vld && w_rdy;
  assign w_last = (r_state == WAIT) && (r_cnt == C_LAST);

`ifdef FARROW_CTRL_ZERO_MU_SKIP_EN
  assign w_skip = (s_delay == '0);
`else
  assign w_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_hs) w_next = w_skip ? OUT : ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (w_last) w_next = (r_k == '0) ? OUT : ISSUE;
      OUT:   begin
        if (w_hs) w_next = w_skip ? OUT : ISSUE;
        else      w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs: handshake/status decoded from state; mult_sum operands come
  // straight from held registers, which only change at a pass boundary, so
  // they remain stable across ISSUE and the whole WAIT window.
  always_comb begin
    s_rdy       = w_rdy;
    busy        = (r_state != IDLE);
    ms_vld      = (r_state == ISSUE);
    m_vld       = (r_state == OUT);
    ms_data_in  = r_acc;
    ms_delay    = r_mu;
    ms_data_fir = r_c[r_k];
    m_data      = r_m_data;
  end

  // Datapath: sample capture on handshake, pass counting and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= ORDER; i++) r_c[i] <= '0;
      r_mu     <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_m_data <= '0;
    end else begin
      if (w_hs) begin
        for (int unsigned i = 0; i <= ORDER; i++)
          r_c[i] <= s_coef[i*wight_data +: wight_data];
        r_mu  <= s_delay;
        r_acc <= s_coef[ORDER*wight_data +: wight_data];
        r_k   <= K_TOP;
        if (w_skip) r_m_data <= s_coef[wight_data-1:0];
      end
      if (r_state == ISSUE) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_acc <= ms_data_out;
        if (r_k == '0) r_m_data <= ms_data_out;
        else           r_k <= r_k - 1'b1;
      end
    end
  end

endmodule

// File: doc/farrow_ctrl.md
# farrow_ctrl

Horner-scheme sequencer that time-shares one `mult_sum` multiply-round-add stage across all polynomial branches of the Farrow fractional-delay filter. It sits between the FIR branch bank and the shared `mult_sum` instance. For each input sample it evaluates y = (…(c[ORDER]·mu + c[ORDER-1])·mu + … )·mu + c[0]. It does this by issuing ORDER requests into `mult_sum`, waiting out its pipeline each time and feeding the result back, then presents y on a valid-only output.

## Interface
- `wight_data`, 20: width of branch samples, `mult_sum` data ports and output.
- `wight_delay`, 18: width of fractional delay mu.
- `ORDER`, 3: polynomial order; number of `mult_sum` passes per sample (≥1).
- `LAT`, 3: cycles from a `ms_vld` high cycle to valid `ms_data_out` (≥1).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_vld` in 1: input sample valid.
- `s_rdy` out 1: block can accept a sample.
- `s_coef` in (ORDER+1)·wight_data: branch outputs, c[0] at LSBs, c[ORDER] at MSBs, signed.
- `s_delay` in wight_delay: mu for this sample.
- `ms_data_in` out wight_data: to `mult_sum.data_in` (accumulator).
- `ms_delay` out wight_delay: to `mult_sum.delay`.
- `ms_data_fir` out wight_data: to `mult_sum.data_fir` (current c[k]).
- `ms_vld` out 1: to `mult_sum.vld_in`, one-cycle pulse per pass.
- `ms_data_out` in wight_data: from `mult_sum.data_out`.
- `m_vld` out 1: output valid, one-cycle pulse.
- `m_data` out wight_data: filtered sample y.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: `s_rdy`=1. On `s_vld`&`s_rdy`, register all of `s_coef` and `s_delay`. Load acc←c[ORDER] and k←ORDER-1, then go to ISSUE.
- ISSUE, one cycle: `ms_vld`=1, `ms_data_in`=acc, `ms_data_fir`=c[k], `ms_delay`=mu. Go to WAIT and clear the wait counter.
- WAIT: count LAT cycles. `ms_data_in`, `ms_data_fir` and `ms_delay` stay stable for the whole pass.
  - In the LAT-th cycle after ISSUE, capture acc←`ms_data_out`.
  - If k==0, also load `m_data`←`ms_data_out` and go to OUT.
  - Otherwise decrement k and go to ISSUE.
- OUT, one cycle: `m_vld`=1 and `s_rdy`=1. A handshake here starts the next sample directly in ISSUE. Otherwise go to IDLE.
- `m_data` holds its value until the next OUT.
- `ms_vld` pulses are at least LAT+1 cycles apart, so `mult_sum` never holds two passes in flight. Its CE-gated adders are therefore always coherent.
- Arithmetic, rounding and shift are owned entirely by `mult_sum`. The controller only moves words; there is no width change.
- `s_coef` and `s_delay` are ignored outside a handshake cycle, and the held copies are not disturbed mid-sample.

## Timing
- Handshake in cycle 0 → first ISSUE in cycle 1. Pass period is LAT+1. `m_vld` is high in cycle ORDER·(LAT+1)+1; that is cycle 13 at the defaults.
- Throughput: one sample per ORDER·(LAT+1)+1 cycles with back-to-back handshakes in OUT.
- Reset (`rst`=0), effective immediately:
  - State is IDLE, so `s_rdy`=1.
  - `busy`=0, `ms_vld`=0, `m_vld`=0.
  - `ms_data_in`, `ms_delay`, `ms_data_fir`, `m_data`, acc, k and the counter are all 0.
- Reset mid-sample aborts the sample with no `m_vld`. A pass already in flight in `mult_sum` is discarded, because the controller never enters a capture cycle for it.

## Configuration
- `FARROW_CTRL_ZERO_MU_SKIP_EN` defined:
  - A handshake with `s_delay`==0 bypasses `mult_sum`. The block goes IDLE→OUT with `m_data`=c[0], `m_vld` in cycle 1, and no `ms_vld` pulse.
- `FARROW_CTRL_ZERO_MU_SKIP_EN` undefined:
  - mu=0 takes the full ORDER passes.
  - The result equals c[0] because `mult_sum` rounding of a zero product is 0. Only the latency differs.

## Test plan
The bench uses a behavioural `mult_sum` model with LAT=3 and out=((a·d+2^19)>>>20)+f; the DUT runs with ORDER=3.
- c[3..0]={0,0,1600,7}, mu=65536 → exactly 3 `ms_vld` pulses at cycles 1, 5 and 9; `m_vld` at cycle 13 with `m_data`=107.
- Two back-to-back samples, `s_vld` held high → second handshake taken in the OUT cycle (cycle 13). Second `m_vld` at cycle 26.
- c[0]=-5, others 0, mu=0:
  - Macro undefined → `m_data`=-5 at cycle 13.
  - Macro defined → `m_data`=-5 at cycle 1 with no `ms_vld`.
- `rst` low at cycle 6 of a sample → outputs at their reset values immediately, no `m_vld`. A fresh sample after release yields the correct result.
- `s_coef` and `s_delay` toggled randomly while `busy`=1 → `ms_*` stable during WAIT and the result unchanged (107 for the first vector).
